// File: rtl/fetch_stage_if.sv
// Bundles the fetch-stage control, IMEM and IF/ID signals.
// The slave modport is the fetch stage; the master modport is the hazard/IMEM/decode side.
interface fetch_stage_if;
  logic        iStallF;
  logic        iStallD;
  logic        iFlushD;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic [31:0] oImemAddr;
  logic [31:0] iImemRdata;
  logic [31:0] oPcF;
  logic [31:0] oInstD;
  logic [31:0] oPcPlus4D;
  logic        oValidD;
  logic [31:0] oFetchCount;
  logic [31:0] oBubbleCount;

  modport slave (
    input  iStallF, iStallD, iFlushD, iRedirect, iRedirectPc, iImemRdata,
    output oImemAddr, oPcF, oInstD, oPcPlus4D, oValidD, oFetchCount, oBubbleCount
  );

  modport master (
    output iStallF, iStallD, iFlushD, iRedirect, iRedirectPc, iImemRdata,
    input  oImemAddr, oPcF, oInstD, oPcPlus4D, oValidD, oFetchCount, oBubbleCount
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IMEM address and IF/ID pipeline register.
// Define FETCH_PERF_EN to build the fetch/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic          iClk,
  input logic          iReset,
  fetch_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] instD;
  logic [XLEN-1:0] pcPlus4D;
  logic            validD;
  logic            redirectTaken;
  logic            loadBubble;
  logic            loadInst;

  assign pcPlus4       = pc + XLEN'(4);
  assign redirectTaken = bus.iRedirect & ~bus.iStallF;
  assign loadBubble    = bus.iFlushD | redirectTaken;
  assign loadInst      = ~loadBubble & ~bus.iStallD;

  // PC: stall holds, so a pending redirect waits until the stall drops
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pc <= RESET_PC;
    end else if (bus.iStallF) begin
      pc <= pc;
    end else if (bus.iRedirect) begin
      pc <= {bus.iRedirectPc[XLEN-1:2], 2'b00};
    end else begin
      pc <= pcPlus4;
    end
  end

  // IF/ID: a taken redirect squashes the wrong-path word (no delay slot)
  always_ff @(posedge iClk) begin
    if (iReset) begin
      instD    <= NOP_INST;
      pcPlus4D <= '0;
      validD   <= 1'b0;
    end else if (loadBubble) begin
      instD    <= NOP_INST;
      pcPlus4D <= pcPlus4;
      validD   <= 1'b0;
    end else if (loadInst) begin
      instD    <= bus.iImemRdata;
      pcPlus4D <= pcPlus4;
      validD   <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetchCount;
  logic [XLEN-1:0] bubbleCount;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      fetchCount  <= '0;
      bubbleCount <= '0;
    end else begin
      if (loadInst)   fetchCount  <= fetchCount + XLEN'(1);
      if (loadBubble) bubbleCount <= bubbleCount + XLEN'(1);
    end
  end

  assign bus.oFetchCount  = fetchCount;
  assign bus.oBubbleCount = bubbleCount;
`else
  assign bus.oFetchCount  = '0;
  assign bus.oBubbleCount = '0;
`endif

  assign bus.oImemAddr = pc;
  assign bus.oPcF      = pc;
  assign bus.oInstD    = instD;
  assign bus.oPcPlus4D = pcPlus4D;
  assign bus.oValidD   = validD;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random control
// traffic compared against an instruction-stream reference model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic iClk = 1'b0;
  logic iReset;
  int   nChecks = 0;
  int   nPass   = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] imemWord(input logic [31:0] addr);
    return 32'h2000_0000 + (addr >> 2);
  endfunction

  assign bus.iImemRdata = imemWord(bus.oImemAddr);

  // The hazard unit never stalls fetch without also stalling decode
  always @(posedge iClk) begin
    if (!iReset) assert (!(bus.iStallF && !bus.iStallD)) else $error("illegal stall combination");
  end

  // Reference model: what decode should see
  logic [31:0] mPc, mInst, mPcPlus4;
  logic        mValid;
  int unsigned mFetches, mBubbles;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic modelEdge();
    logic [31:0] fetchedFrom;
    if (iReset) begin
      mPc = RESET_PC; mInst = NOP_INST; mPcPlus4 = 0; mValid = 0;
      mFetches = 0; mBubbles = 0;
    end else begin
      fetchedFrom = mPc;
      if (bus.iFlushD || (bus.iRedirect && !bus.iStallF)) begin
        mInst = NOP_INST; mValid = 0; mPcPlus4 = fetchedFrom + 4; mBubbles++;
      end else if (!bus.iStallD) begin
        mInst = imemWord(fetchedFrom); mValid = 1; mPcPlus4 = fetchedFrom + 4; mFetches++;
      end
      if (!bus.iStallF)
        mPc = bus.iRedirect ? (bus.iRedirectPc & 32'hFFFF_FFFC) : fetchedFrom + 4;
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".pc"},    bus.oPcF,      mPc);
    checkVal({tag, ".addr"},  bus.oImemAddr, mPc);
    checkVal({tag, ".inst"},  bus.oInstD,    mInst);
    checkVal({tag, ".pc4"},   bus.oPcPlus4D, mPcPlus4);
    checkVal({tag, ".valid"}, 32'(bus.oValidD), 32'(mValid));
`ifdef FETCH_PERF_EN
    checkVal({tag, ".fcnt"},  bus.oFetchCount,  mFetches);
    checkVal({tag, ".bcnt"},  bus.oBubbleCount, mBubbles);
`else
    checkVal({tag, ".fcnt"},  bus.oFetchCount,  32'd0);
    checkVal({tag, ".bcnt"},  bus.oBubbleCount, 32'd0);
`endif
  endtask

  task automatic drive(input logic rst, input logic sf, input logic sd, input logic fl,
                       input logic rd, input logic [31:0] rpc);
    iReset = rst; bus.iStallF = sf; bus.iStallD = sd; bus.iFlushD = fl;
    bus.iRedirect = rd; bus.iRedirectPc = rpc;
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge iClk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    mPc = 0; mInst = 0; mPcPlus4 = 0; mValid = 0; mFetches = 0; mBubbles = 0;
    step("reset");
    checkVal("rst_addr", bus.oImemAddr, RESET_PC);
    checkVal("rst_valid", 32'(bus.oValidD), 32'd0);

    drive(0, 0, 0, 0, 0, 0);
    step("rel1");
    checkVal("rel1_inst", bus.oInstD, 32'h2000_0000);
    checkVal("rel1_pc4", bus.oPcPlus4D, 32'd4);
    step("rel2");
    checkVal("rel2_inst", bus.oInstD, 32'h2000_0001);
    checkVal("rel2_pc4", bus.oPcPlus4D, 32'd8);

    drive(0, 1, 1, 0, 0, 0);
    repeat (3) step("stall");
    checkVal("stall_pc", bus.oPcF, 32'd8);
    checkVal("stall_inst", bus.oInstD, 32'h2000_0001);
    drive(0, 0, 0, 0, 0, 0);
    step("unstall");
    checkVal("unstall_pc", bus.oPcF, 32'd12);
    checkVal("unstall_inst", bus.oInstD, 32'h2000_0002);
    step("seq16");
    checkVal("seq16_pc", bus.oPcF, 32'd16);

    drive(0, 0, 0, 0, 1, 32'h0000_0043);
    step("redir");
    checkVal("redir_pc", bus.oPcF, 32'h40);
    checkVal("redir_valid", 32'(bus.oValidD), 32'd0);
    checkVal("redir_inst", bus.oInstD, NOP_INST);
    drive(0, 0, 0, 0, 0, 0);
    step("redir2");
    checkVal("redir2_inst", bus.oInstD, imemWord(32'h40));
    checkVal("redir2_pc4", bus.oPcPlus4D, 32'h44);

    drive(0, 1, 1, 0, 1, 32'h100);
    repeat (2) step("rdstall");
    checkVal("rdstall_pc", bus.oPcF, 32'h44);
    drive(0, 0, 0, 0, 1, 32'h100);
    step("rdgo");
    checkVal("rdgo_pc", bus.oPcF, 32'h100);

    drive(0, 0, 1, 1, 0, 0);
    step("flushstall");
    checkVal("fs_valid", 32'(bus.oValidD), 32'd0);
    checkVal("fs_inst", bus.oInstD, 32'd0);

    drive(1, 0, 0, 0, 1, 32'h200);
    step("midrst");
    checkVal("midrst_pc", bus.oPcF, RESET_PC);
    checkVal("midrst_pc4", bus.oPcPlus4D, 32'd0);

    // Perf scenario: 10 sequential fetches, one flush, one redirect
    drive(0, 0, 0, 0, 0, 0);
    repeat (10) step("perfseq");
    drive(0, 0, 0, 1, 0, 0);
    step("perfflush");
    drive(0, 0, 0, 0, 1, 32'h80);
    step("perfredir");
`ifdef FETCH_PERF_EN
    checkVal("perf_fetch", bus.oFetchCount, 32'd10);
    checkVal("perf_bubble", bus.oBubbleCount, 32'd2);
`else
    checkVal("perf_fetch", bus.oFetchCount, 32'd0);
    checkVal("perf_bubble", bus.oBubbleCount, 32'd0);
`endif

    // Random control traffic, including redirects to the top of memory to hit PC wrap
    for (int i = 0; i < 400; i++) begin
      logic sf, sd, fl, rd, rst;
      logic [31:0] tgt;
      sf  = ($urandom % 5) == 0;
      sd  = sf | (($urandom % 6) == 0);
      fl  = ($urandom % 8) == 0;
      rd  = ($urandom % 7) == 0;
      rst = ($urandom % 60) == 0;
      tgt = (($urandom % 4) == 0) ? 32'hFFFF_FFF4 + ($urandom % 4) : $urandom;
      drive(rst, sf, sd, fl, rd, tgt);
      step("rand");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
